// File: rtl/priority_encoder.sv
// Registered priority encoder: the highest-priority set bit of a becomes
// index y, one-hot mask onehot and flag valid, one clock after capture.
module priority_encoder #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned IDX_W     = $clog2(WIDTH),
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [IDX_W-1:0] y,
  output logic             valid,
  output logic [WIDTH-1:0] onehot
);

  // Enough doubling steps for a prefix-OR to span the whole vector.
  localparam int unsigned NSTAGE = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [NSTAGE:0][WIDTH-1:0] w_pre;
  logic [WIDTH-1:0]           w_prefix;
  logic [WIDTH-1:0]           w_onehot;
  logic [IDX_W-1:0]           w_idx;
  logic                       w_valid;

  assign w_pre[0] = a;

  // Log-depth prefix-OR toward the low-priority end, so each bit learns
  // whether any request at or above its own priority is asserted.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_prefix
    localparam int unsigned SH = 1 << k;
    if (MSB_FIRST) begin : g_down
      assign w_pre[k+1] = w_pre[k] | (w_pre[k] >> SH);
    end else begin : g_up
      assign w_pre[k+1] = w_pre[k] | (w_pre[k] << SH);
    end
  end

  assign w_prefix = w_pre[NSTAGE];

  // A bit wins when it is set and no strictly higher-priority bit is set.
  if (MSB_FIRST) begin : g_win_msb
    assign w_onehot = a & ~(w_prefix >> 1);
  end else begin : g_win_lsb
    assign w_onehot = a & ~(w_prefix << 1);
  end

  assign w_valid = |a;

  // Encode the one-hot winner into a binary index with a pure OR tree.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_onehot[i]) begin
        w_idx = w_idx | IDX_W'(i);
      end
    end
  end

  // Output registers: synchronous reset wins over enable; en=0 holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y      <= '0;
      valid  <= 1'b0;
      onehot <= '0;
    end else if (en) begin
      y      <= w_idx;
      valid  <= w_valid;
      onehot <= w_onehot;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder: default 4-bit MSB-first, 4-bit LSB-first and
// 16-bit MSB-first instances, checked against a scan-based reference model.
module tb_priority_encoder;

  typedef struct packed {
    logic [3:0]  y;
    logic        valid;
    logic [15:0] onehot;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  a4, al;
  logic [15:0] a16;
  logic [1:0]  y4, yl;
  logic [3:0]  y16;
  logic        v4, vl, v16;
  logic [3:0]  oh4, ohl;
  logic [15:0] oh16;

  exp_t q4[$], ql[$], q16[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  priority_encoder #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a4), .y(y4), .valid(v4), .onehot(oh4));
  priority_encoder #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .a(al), .y(yl), .valid(vl), .onehot(ohl));
  priority_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a16), .y(y16), .valid(v16), .onehot(oh16));

  // Reference: linear scan, last hit wins for MSB-first, first hit for LSB-first.
  function automatic exp_t model(input logic [15:0] av, input int w, input bit msb);
    exp_t e;
    int   win;
    e   = '0;
    win = -1;
    for (int i = 0; i < w; i++) begin
      if (av[i] && (msb || win < 0)) win = i;
    end
    if (win >= 0) begin
      e.valid  = 1'b1;
      e.y      = 4'(win);
      e.onehot = 16'(1) << win;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; en = 1'b1; a4 = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      q4.push_back('0);
      step();
      e = q4.pop_front();
      n_tests++;
      if ({y4, v4, oh4} !== {e.y[1:0], e.valid, e.onehot[3:0]}) begin
        n_fail++;
        $display("FAIL reset_hold: y=%b valid=%b onehot=%b, expected y=%b valid=%b onehot=%b",
                 y4, v4, oh4, e.y[1:0], e.valid, e.onehot[3:0]);
      end
    end
    rst_n = 1'b1;
    q4.push_back(model(16'(a4), 4, 1'b1));
    step();
    e = q4.pop_front();
    n_tests++;
    if ({y4, v4, oh4} !== {2'b11, 1'b1, 4'b1000}) begin
      n_fail++;
      $display("FAIL reset_release: y=%b valid=%b onehot=%b, expected y=11 valid=1 onehot=1000",
               y4, v4, oh4);
    end
    n_tests++;
    if ({y4, v4, oh4} !== {e.y[1:0], e.valid, e.onehot[3:0]}) begin
      n_fail++;
      $display("FAIL reset_release_model: y=%b valid=%b onehot=%b, expected y=%b valid=%b onehot=%b",
               y4, v4, oh4, e.y[1:0], e.valid, e.onehot[3:0]);
    end
  endtask

  task automatic test_sweep();
    logic [1:0] req_y [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    logic       req_v [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t e;
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      a4 = 4'(k);
      e  = '0;
      e.y = {2'b00, req_y[k]};
      e.valid = req_v[k];
      q4.push_back(e);
      step();
      e = q4.pop_front();
      n_tests++;
      if ({y4, v4} !== {e.y[1:0], e.valid}) begin
        n_fail++;
        $display("FAIL sweep a=%b: y=%b valid=%b, expected y=%b valid=%b",
                 4'(k), y4, v4, e.y[1:0], e.valid);
      end
    end
  endtask

  task automatic test_exhaustive();
    exp_t e;
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      a4 = 4'(k);
      q4.push_back(model(16'(a4), 4, 1'b1));
      step();
      e = q4.pop_front();
      n_tests++;
      if ({y4, v4, oh4} !== {e.y[1:0], e.valid, e.onehot[3:0]}) begin
        n_fail++;
        $display("FAIL exhaustive a=%b: y=%b valid=%b onehot=%b, expected y=%b valid=%b onehot=%b",
                 4'(k), y4, v4, oh4, e.y[1:0], e.valid, e.onehot[3:0]);
      end
      n_tests++;
      if ($countones(oh4) > 1) begin
        n_fail++;
        $display("FAIL onehot_count a=%b: onehot=%b, expected at most one bit set", 4'(k), oh4);
      end
    end
  endtask

  task automatic test_enable_hold();
    exp_t e, held;
    en = 1'b1; a4 = 4'b0100;
    held = model(16'(a4), 4, 1'b1);
    q4.push_back(held);
    step();
    e = q4.pop_front();
    n_tests++;
    if (y4 !== 2'b10 || y4 !== e.y[1:0]) begin
      n_fail++;
      $display("FAIL hold_capture: y=%b, expected y=10", y4);
    end
    en = 1'b0; a4 = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      q4.push_back(held);
      step();
      e = q4.pop_front();
      n_tests++;
      if ({y4, v4, oh4} !== {e.y[1:0], e.valid, e.onehot[3:0]}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: y=%b valid=%b onehot=%b, expected y=%b valid=%b onehot=%b",
                 k, y4, v4, oh4, e.y[1:0], e.valid, e.onehot[3:0]);
      end
    end
    en = 1'b1;
    q4.push_back(model(16'(a4), 4, 1'b1));
    step();
    e = q4.pop_front();
    n_tests++;
    if ({y4, v4, oh4} !== {e.y[1:0], e.valid, e.onehot[3:0]} || y4 !== 2'b11) begin
      n_fail++;
      $display("FAIL hold_release: y=%b valid=%b onehot=%b, expected y=11 valid=1 onehot=1000",
               y4, v4, oh4);
    end
  endtask

  task automatic test_lsb_priority();
    logic [3:0] vec   [3] = '{4'b0110, 4'b1000, 4'b1111};
    logic [1:0] req_y [3] = '{2'b01, 2'b11, 2'b00};
    exp_t e;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      al = vec[k];
      ql.push_back(model(16'(al), 4, 1'b0));
      step();
      e = ql.pop_front();
      n_tests++;
      if ({yl, vl, ohl} !== {e.y[1:0], e.valid, e.onehot[3:0]} || yl !== req_y[k]) begin
        n_fail++;
        $display("FAIL lsb a=%b: y=%b valid=%b onehot=%b, expected y=%b valid=%b onehot=%b",
                 vec[k], yl, vl, ohl, req_y[k], e.valid, e.onehot[3:0]);
      end
    end
  endtask

  task automatic test_wide();
    logic [15:0] vec   [3] = '{16'h0001, 16'h8001, 16'h0000};
    logic [3:0]  req_y [3] = '{4'd0, 4'd15, 4'd0};
    exp_t e;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a16 = vec[k];
      q16.push_back(model(a16, 16, 1'b1));
      step();
      e = q16.pop_front();
      n_tests++;
      if ({y16, v16, oh16} !== {e.y, e.valid, e.onehot} || y16 !== req_y[k]) begin
        n_fail++;
        $display("FAIL wide a=%h: y=%0d valid=%b onehot=%h, expected y=%0d valid=%b onehot=%h",
                 vec[k], y16, v16, oh16, req_y[k], e.valid, e.onehot);
      end
    end
    // Reset in the middle of a live stream clears every output on that edge.
    a16 = 16'h8001; a4 = 4'b1111; rst_n = 1'b0;
    q16.push_back('0);
    step();
    e = q16.pop_front();
    n_tests++;
    if ({y16, v16, oh16, y4, v4, oh4} !== {e.y, e.valid, e.onehot, 2'b00, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL wide_midreset: y16=%0d valid=%b onehot=%h y4=%b v4=%b, expected all zero",
               y16, v16, oh16, y4, v4);
    end
    rst_n = 1'b1; a16 = 16'h0400;
    q16.push_back(model(a16, 16, 1'b1));
    step();
    e = q16.pop_front();
    n_tests++;
    if ({y16, v16, oh16} !== {e.y, e.valid, e.onehot}) begin
      n_fail++;
      $display("FAIL wide_after_reset: y=%0d valid=%b onehot=%h, expected y=%0d valid=%b onehot=%h",
               y16, v16, oh16, e.y, e.valid, e.onehot);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, p16, pl;
    p16 = model(a16, 16, 1'b1);
    pl  = model(16'(al), 4, 1'b0);
    for (int k = 0; k < 60; k++) begin
      en  = ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom) >> $urandom_range(0, 15);
      al  = 4'($urandom);
      if (en) begin
        p16 = model(a16, 16, 1'b1);
        pl  = model(16'(al), 4, 1'b0);
      end
      q16.push_back(p16);
      ql.push_back(pl);
      step();
      e = q16.pop_front();
      n_tests++;
      if ({y16, v16, oh16} !== {e.y, e.valid, e.onehot}) begin
        n_fail++;
        $display("FAIL b2b_wide cyc%0d: y=%0d valid=%b onehot=%h, expected y=%0d valid=%b onehot=%h",
                 k, y16, v16, oh16, e.y, e.valid, e.onehot);
      end
      e = ql.pop_front();
      n_tests++;
      if ({yl, vl, ohl} !== {e.y[1:0], e.valid, e.onehot[3:0]}) begin
        n_fail++;
        $display("FAIL b2b_lsb cyc%0d: y=%b valid=%b onehot=%b, expected y=%b valid=%b onehot=%b",
                 k, yl, vl, ohl, e.y[1:0], e.valid, e.onehot[3:0]);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    a4    = 4'b1111;
    al    = '0;
    a16   = '0;
    test_reset();
    test_sweep();
    test_exhaustive();
    test_enable_hold();
    test_lsb_priority();
    test_wide();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
